// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_seq shared package: opcodes,
// alu_op encodings and FSM state type.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_R_ARITH = 4'b0000;
  localparam logic [3:0] OP_I_ARITH = 4'b1000;
  localparam logic [3:0] OP_LW      = 4'b1001;
  localparam logic [3:0] OP_SW      = 4'b0101;
  localparam logic [3:0] OP_JMP     = 4'b1011;
  localparam logic [3:0] OP_R_CMP   = 4'b0010;
  localparam logic [3:0] OP_I_CMP   = 4'b1010;
  localparam logic [3:0] OP_BR      = 4'b0110;

  localparam logic [1:0] ALU_ARITH  = 2'b01;
  localparam logic [1:0] ALU_CMP    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULTI = 2'd1,
    VALID = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode-side and issue-side handshake bundle.
// slave: the ALU-control stage; master: its environment.
interface alu_ctrl_seq_if #(
  parameter int OPW = 4,
  parameter int FW  = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [OPW-1:0] opcode;
  logic [FW-1:0] func;
  logic [FW-1:0] func_imm_lw;
  logic [FW-1:0] func_br_sw;
  logic          out_valid;
  logic          out_ready;
  logic [FW+1:0] alu_ctrl;
  logic          illegal;
  logic          busy;

  modport slave (
    input  in_valid, opcode, func,
    input  func_imm_lw, func_br_sw,
    input  out_ready,
    output in_ready, out_valid,
    output alu_ctrl, illegal, busy
  );

  modport master (
    output in_valid, opcode, func,
    output func_imm_lw, func_br_sw,
    output out_ready,
    input  in_ready, out_valid,
    input  alu_ctrl, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decode: alu_ctrl,
// illegal flag and multi-cycle classification.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int             OPW     = 4,
  parameter int             FW      = 4,
  parameter logic [FW-1:0]  MC_FUNC = FW'(4'b1100)
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  func,
  input  logic [FW-1:0]  func_imm_lw,
  input  logic [FW-1:0]  func_br_sw,
  output logic [FW+1:0]  alu_ctrl,
  output logic           illegal,
  output logic           is_multi
);

  logic [1:0]    op;
  logic [FW-1:0] fld;

  always_comb begin
    op      = ALU_CMP;
    fld     = '0;
    illegal = 1'b0;
    unique case (opcode)
      OPW'(OP_R_ARITH): begin
        op  = ALU_ARITH;
        fld = func;
      end
      OPW'(OP_I_ARITH),
      OPW'(OP_LW),
      OPW'(OP_JMP): begin
        op  = ALU_ARITH;
        fld = func_imm_lw;
      end
      OPW'(OP_SW): begin
        op  = ALU_ARITH;
        fld = func_br_sw;
      end
      OPW'(OP_R_CMP): begin
        op  = ALU_CMP;
        fld = func;
      end
      OPW'(OP_I_CMP): begin
        op  = ALU_CMP;
        fld = func_imm_lw;
      end
      OPW'(OP_BR): begin
        op  = ALU_BRANCH;
        fld = func_br_sw;
      end
      default: illegal = 1'b1;
    endcase
    alu_ctrl = {op, fld};
    is_multi = !illegal &&
               (op == ALU_ARITH) &&
               (fld == MC_FUNC);
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control stage with multi-cycle
// sequencing, illegal flag and synchronous flush.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int            OPW     = 4,
  parameter int            FW      = 4,
  parameter logic [FW-1:0] MC_FUNC = FW'(4'b1100),
  parameter int            MC_LAT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  alu_ctrl_seq_if.slave bus
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW+1:0] ctrl_q, ctrl_d;
  logic          ill_q, ill_d;

  logic [FW+1:0] dec_ctrl;
  logic          dec_ill;
  logic          dec_multi;
  logic          in_ready;
  logic          accept;

  alu_ctrl_decode #(
    .OPW     (OPW),
    .FW      (FW),
    .MC_FUNC (MC_FUNC)
  ) u_dec (
    .opcode      (bus.opcode),
    .func        (bus.func),
    .func_imm_lw (bus.func_imm_lw),
    .func_br_sw  (bus.func_br_sw),
    .alu_ctrl    (dec_ctrl),
    .illegal     (dec_ill),
    .is_multi    (dec_multi)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    ill_d    = ill_q;
    in_ready = !flush &&
               ((state_q == IDLE) ||
                ((state_q == VALID) && bus.out_ready));
    accept   = bus.in_valid && in_ready;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ctrl_d  = '0;
      ill_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        MULTI: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_d = VALID;
        end
        VALID: begin
          if (bus.out_ready)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      // acceptance only happens from IDLE or a
      // draining VALID, so it overrides the above
      if (accept) begin
        ctrl_d = dec_ctrl;
        ill_d  = dec_ill;
        if (dec_multi) begin
          state_d = MULTI;
          cnt_d   = CW'(MC_LAT - 1);
        end else begin
          state_d = VALID;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == VALID);
  assign bus.busy      = (state_q == MULTI);
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.illegal   = ill_q;

endmodule
